// File: rtl/vector_csr_file.sv
// Vector CSR file: holds vstart/vxsat/vxrm/vcsr/vl/vtype/vlenb, executes
// vsetvl-family requests with a registered one-cycle response, and serves
// Zicsr-style read/write/set/clear accesses.
module vector_csr_file #(
  parameter int VLEN = 128,
  parameter int ELEN = 32,
  parameter int XLEN = 32,
  localparam int VLENB = VLEN / 8,
  localparam int VL_W  = $clog2(VLEN) + 1,
  localparam int VS_W  = $clog2(VLEN)
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [XLEN-1:0] cfg_avl,
  input  logic [XLEN-1:0] cfg_vtype,
  input  logic            cfg_rs1_zero,
  input  logic            cfg_rd_zero,
  output logic            cfg_resp_valid,
  output logic [XLEN-1:0] cfg_resp_vl,
  input  logic            csr_req,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            sat_set,
  input  logic            vstart_inc,
  output logic [VL_W-1:0] vl,
  output logic [2:0]      vsew,
  output logic [2:0]      vlmul,
  output logic            vta,
  output logic            vma,
  output logic            vill,
  output logic [1:0]      vxrm,
  output logic            vxsat,
  output logic [VS_W-1:0] vstart
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RESP = 1'b1;

  localparam logic [11:0] A_VSTART = 12'h008;
  localparam logic [11:0] A_VXSAT  = 12'h009;
  localparam logic [11:0] A_VXRM   = 12'h00A;
  localparam logic [11:0] A_VCSR   = 12'h00F;
  localparam logic [11:0] A_VL     = 12'hC20;
  localparam logic [11:0] A_VTYPE  = 12'hC21;
  localparam logic [11:0] A_VLENB  = 12'hC22;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  // Largest legal vsew encoding: log2(ELEN/8).
  localparam logic [2:0] SEW_MAX = 3'($clog2(ELEN / 8));

  logic [0:0]      state_q, state_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic            vill_q, vill_d, vma_q, vma_d, vta_q, vta_d;
  logic [2:0]      vsew_q, vsew_d, vlmul_q, vlmul_d;
  logic [VS_W-1:0] vstart_q, vstart_d;
  logic            vxsat_q, vxsat_d;
  logic [1:0]      vxrm_q, vxrm_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_vl_q, resp_vl_d;

  logic [2:0]      req_vsew, req_vlmul;
  logic [XLEN-1:0] vlmax, sew_bits, elen_scaled, new_vl;
  logic            req_vill;

  logic            csr_known, csr_ro, csr_bad, csr_we;
  logic [XLEN-1:0] csr_old;
  logic [VS_W-1:0] csr_new;

  // Decode the vset request: vtype legality, VLMAX and the resulting vl.
  always_comb begin
    // NOTE: every variable gets a default at the top of a combinational
    // block so no path leaves it unassigned, which would infer a latch.
    req_vsew    = cfg_vtype[5:3];
    req_vlmul   = cfg_vtype[2:0];
    sew_bits    = XLEN'(8) << req_vsew;
    elen_scaled = XLEN'(ELEN) >> (4'd8 - {1'b0, req_vlmul});
    vlmax       = XLEN'(VLEN) >> (4'd3 + {1'b0, req_vsew});
    if (!req_vlmul[2]) vlmax = vlmax << req_vlmul[1:0];
    else               vlmax = vlmax >> (4'd8 - {1'b0, req_vlmul});

    req_vill = (req_vsew > SEW_MAX) || (req_vlmul == 3'b100) ||
               (req_vlmul[2] && (sew_bits > elen_scaled)) ||
               (cfg_vtype[XLEN-2:8] != '0) || cfg_vtype[XLEN-1];

    new_vl = vlmax;
    if (!cfg_rs1_zero) begin
      new_vl = (cfg_avl < vlmax) ? cfg_avl : vlmax;
    end else if (cfg_rd_zero) begin
      // Keep-vl form: only legal if the current vl still fits the new VLMAX.
      new_vl = XLEN'(vl_q);
      if (XLEN'(vl_q) > vlmax) req_vill = 1'b1;
    end
    if (req_vill) new_vl = '0;
  end

  // Decode the CSR access: old value, legality and the read-modify-write result.
  always_comb begin
    csr_known = 1'b1;
    csr_ro    = 1'b0;
    csr_old   = '0;
    case (csr_addr)
      A_VSTART: csr_old = XLEN'(vstart_q);
      A_VXSAT:  csr_old = XLEN'(vxsat_q);
      A_VXRM:   csr_old = XLEN'(vxrm_q);
      A_VCSR:   csr_old = XLEN'({vxrm_q, vxsat_q});
      A_VL:     begin csr_ro = 1'b1; csr_old = XLEN'(vl_q); end
      A_VTYPE:  begin
        csr_ro  = 1'b1;
        csr_old = {vill_q, {(XLEN-9){1'b0}}, vma_q, vta_q, vsew_q, vlmul_q};
      end
      A_VLENB:  begin csr_ro = 1'b1; csr_old = XLEN'(VLENB); end
      default:  csr_known = 1'b0;
    endcase

    // vstart is the widest writable field, so VS_W bits cover every target.
    case (csr_op)
      OP_RW:   csr_new = csr_wdata[VS_W-1:0];
      OP_RS:   csr_new = csr_old[VS_W-1:0] | csr_wdata[VS_W-1:0];
      OP_RC:   csr_new = csr_old[VS_W-1:0] & ~csr_wdata[VS_W-1:0];
      default: csr_new = csr_old[VS_W-1:0];
    endcase

    csr_bad = !csr_known || (csr_ro && (csr_op == OP_RW)) ||
              (csr_ro && csr_op[1] && (csr_wdata != '0));
    csr_we  = csr_req && !csr_bad && !csr_ro && (csr_op != OP_READ);
  end

  // Next-state logic; later assignments carry higher priority.
  always_comb begin
    state_d      = state_q;
    vl_d         = vl_q;
    vill_d       = vill_q;
    vma_d        = vma_q;
    vta_d        = vta_q;
    vsew_d       = vsew_q;
    vlmul_d      = vlmul_q;
    vstart_d     = vstart_q;
    vxsat_d      = vxsat_q;
    vxrm_d       = vxrm_q;
    resp_valid_d = 1'b0;
    resp_vl_d    = resp_vl_q;

    if (vstart_inc) vstart_d = vstart_q + VS_W'(1);

    if (csr_we) begin
      case (csr_addr)
        A_VSTART: vstart_d = csr_new;
        A_VXSAT:  vxsat_d  = csr_new[0];
        A_VXRM:   vxrm_d   = csr_new[1:0];
        A_VCSR:   {vxrm_d, vxsat_d} = csr_new[2:0];
        default:  ;
      endcase
    end

    // Lane saturation is sticky and overrides any clearing write.
    vxsat_d = vxsat_d | sat_set;

    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_vl_d    = new_vl;
          vl_d         = new_vl[VL_W-1:0];
          vill_d       = req_vill;
          vma_d        = !req_vill && cfg_vtype[7];
          vta_d        = !req_vill && cfg_vtype[6];
          vsew_d       = req_vill ? 3'b000 : req_vsew;
          vlmul_d      = req_vill ? 3'b000 : req_vlmul;
          vstart_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_reset) begin
    // NOTE: flops use non-blocking assignment so every register samples
    // pre-edge values regardless of statement order.
    if (!n_reset) begin
      state_q      <= S_IDLE;
      vl_q         <= '0;
      vill_q       <= 1'b1;
      vma_q        <= 1'b0;
      vta_q        <= 1'b0;
      vsew_q       <= 3'b000;
      vlmul_q      <= 3'b000;
      vstart_q     <= '0;
      vxsat_q      <= 1'b0;
      vxrm_q       <= 2'b00;
      resp_valid_q <= 1'b0;
      resp_vl_q    <= '0;
    end else begin
      state_q      <= state_d;
      vl_q         <= vl_d;
      vill_q       <= vill_d;
      vma_q        <= vma_d;
      vta_q        <= vta_d;
      vsew_q       <= vsew_d;
      vlmul_q      <= vlmul_d;
      vstart_q     <= vstart_d;
      vxsat_q      <= vxsat_d;
      vxrm_q       <= vxrm_d;
      resp_valid_q <= resp_valid_d;
      resp_vl_q    <= resp_vl_d;
    end
  end

  assign cfg_ready      = (state_q == S_IDLE);
  assign cfg_resp_valid = resp_valid_q;
  assign cfg_resp_vl    = resp_vl_q;
  assign csr_rdata      = csr_old;
  assign csr_illegal    = csr_req && csr_bad;
  assign vl             = vl_q;
  assign vsew           = vsew_q;
  assign vlmul          = vlmul_q;
  assign vta            = vta_q;
  assign vma            = vma_q;
  assign vill           = vill_q;
  assign vxrm           = vxrm_q;
  assign vxsat          = vxsat_q;
  assign vstart         = vstart_q;

endmodule

// File: tb/tb_vector_csr_file.sv
// Directed self-checking bench for vector_csr_file (VLEN=128, ELEN=32).
module tb_vector_csr_file;

  localparam int VLEN = 128;
  localparam int ELEN = 32;
  localparam int XLEN = 32;
  localparam int VL_W = $clog2(VLEN) + 1;
  localparam int VS_W = $clog2(VLEN);

  logic            clk;
  logic            n_reset;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [XLEN-1:0] cfg_avl;
  logic [XLEN-1:0] cfg_vtype;
  logic            cfg_rs1_zero;
  logic            cfg_rd_zero;
  logic            cfg_resp_valid;
  logic [XLEN-1:0] cfg_resp_vl;
  logic            csr_req;
  logic [11:0]     csr_addr;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            sat_set;
  logic            vstart_inc;
  logic [VL_W-1:0] vl;
  logic [2:0]      vsew;
  logic [2:0]      vlmul;
  logic            vta;
  logic            vma;
  logic            vill;
  logic [1:0]      vxrm;
  logic            vxsat;
  logic [VS_W-1:0] vstart;

  int checks = 0;
  int errors = 0;

  vector_csr_file #(.VLEN(VLEN), .ELEN(ELEN), .XLEN(XLEN)) dut (
    .clk(clk), .n_reset(n_reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_avl(cfg_avl), .cfg_vtype(cfg_vtype),
    .cfg_rs1_zero(cfg_rs1_zero), .cfg_rd_zero(cfg_rd_zero),
    .cfg_resp_valid(cfg_resp_valid), .cfg_resp_vl(cfg_resp_vl),
    .csr_req(csr_req), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .sat_set(sat_set), .vstart_inc(vstart_inc),
    .vl(vl), .vsew(vsew), .vlmul(vlmul), .vta(vta), .vma(vma), .vill(vill),
    .vxrm(vxrm), .vxsat(vxsat), .vstart(vstart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one vset at a falling edge; check the RESP cycle and return to IDLE.
  task automatic vset(input string tag, input logic [31:0] avl,
                      input logic [31:0] vt, input logic rs1z, input logic rdz,
                      input logic [31:0] exp_vl, input logic exp_vill);
    cfg_valid    = 1'b1;
    cfg_avl      = avl;
    cfg_vtype    = vt;
    cfg_rs1_zero = rs1z;
    cfg_rd_zero  = rdz;
    #1 check({tag, "_ready_idle"}, 32'(cfg_ready), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check({tag, "_resp_valid"}, 32'(cfg_resp_valid), 32'd1);
    check({tag, "_resp_vl"}, cfg_resp_vl, exp_vl);
    check({tag, "_vl"}, 32'(vl), exp_vl);
    check({tag, "_vill"}, 32'(vill), 32'(exp_vill));
    check({tag, "_ready_resp"}, 32'(cfg_ready), 32'd0);
    @(negedge clk);
    check({tag, "_resp_drop"}, 32'(cfg_resp_valid), 32'd0);
  endtask

  // One-cycle CSR access; checks the combinational response in that cycle.
  task automatic csr_access(input string tag, input logic [1:0] op,
                            input logic [11:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_ill);
    csr_req   = 1'b1;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = wdata;
    #1;
    check({tag, "_rdata"}, csr_rdata, exp_rdata);
    check({tag, "_illegal"}, 32'(csr_illegal), 32'(exp_ill));
    @(negedge clk);
    csr_req = 1'b0;
  endtask

  initial begin
    n_reset = 1'b0; cfg_valid = 1'b0; cfg_avl = '0; cfg_vtype = '0;
    cfg_rs1_zero = 1'b0; cfg_rd_zero = 1'b0; csr_req = 1'b0;
    csr_addr = '0; csr_op = 2'b00; csr_wdata = '0; sat_set = 1'b0;
    vstart_inc = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    #1;
    check("rst_vill", 32'(vill), 32'd1);
    check("rst_vl", 32'(vl), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_resp_valid", 32'(cfg_resp_valid), 32'd0);
    check("rst_resp_vl", cfg_resp_vl, 32'd0);
    check("rst_vstart", 32'(vstart), 32'd0);
    check("rst_vxsat", 32'(vxsat), 32'd0);
    check("rst_vxrm", 32'(vxrm), 32'd0);
    @(negedge clk);
    csr_access("rd_vlenb", 2'b00, 12'hC22, 32'd0, 32'd16, 1'b0);
    csr_access("rd_vtype_rst", 2'b00, 12'hC21, 32'd0, 32'h8000_0000, 1'b0);

    // Normal vsetvli: SEW32 LMUL2 -> VLMAX 8, AVL 10 -> vl 8.
    vset("vs_norm", 32'd10, 32'h0D1, 1'b0, 1'b0, 32'd8, 1'b0);
    check("vs_norm_vsew", 32'(vsew), 32'd2);
    check("vs_norm_vlmul", 32'(vlmul), 32'd1);
    check("vs_norm_vta", 32'(vta), 32'd1);
    check("vs_norm_vma", 32'(vma), 32'd1);
    csr_access("rd_vtype_norm", 2'b00, 12'hC21, 32'd0, 32'h0000_00D1, 1'b0);

    // Illegal and fractional vtypes.
    vset("vs_sew64", 32'd10, 32'h018, 1'b0, 1'b0, 32'd0, 1'b1);
    csr_access("rd_vtype_ill", 2'b00, 12'hC21, 32'd0, 32'h8000_0000, 1'b0);
    vset("vs_frac8", 32'd10, 32'h015, 1'b0, 1'b0, 32'd0, 1'b1);
    vset("vs_frac2", 32'd10, 32'h007, 1'b0, 1'b0, 32'd8, 1'b0);
    vset("vs_rsvd", 32'd10, 32'h100, 1'b0, 1'b0, 32'd0, 1'b1);
    vset("vs_avl_lt", 32'd5, 32'h000, 1'b0, 1'b0, 32'd5, 1'b0);

    // x0 forms.
    vset("vs_x0_max", 32'd0, 32'h003, 1'b1, 1'b0, 32'd128, 1'b0);
    vset("vs_x0_keep_bad", 32'd0, 32'h000, 1'b1, 1'b1, 32'd0, 1'b1);
    vset("vs_avl4", 32'd4, 32'h008, 1'b0, 1'b0, 32'd4, 1'b0);
    vset("vs_x0_keep_ok", 32'd0, 32'h008, 1'b1, 1'b1, 32'd4, 1'b0);

    // Saturation and rounding mode.
    sat_set = 1'b1;
    @(negedge clk);
    sat_set = 1'b0;
    check("sat_pulse", 32'(vxsat), 32'd1);
    sat_set = 1'b1;
    csr_access("rc_vxsat_sat", 2'b11, 12'h009, 32'd1, 32'd1, 1'b0);
    sat_set = 1'b0;
    check("sat_wins", 32'(vxsat), 32'd1);
    csr_access("rc_vxsat", 2'b11, 12'h009, 32'd1, 32'd1, 1'b0);
    check("rc_clears", 32'(vxsat), 32'd0);
    csr_access("rw_vcsr", 2'b01, 12'h00F, 32'h6, 32'd0, 1'b0);
    check("vcsr_vxrm", 32'(vxrm), 32'd3);
    check("vcsr_vxsat", 32'(vxsat), 32'd0);
    csr_access("rd_vcsr", 2'b00, 12'h00F, 32'd0, 32'h6, 1'b0);
    csr_access("rd_vxrm", 2'b00, 12'h00A, 32'd0, 32'h3, 1'b0);

    // Illegal accesses change no state.
    csr_access("rw_vl", 2'b01, 12'hC20, 32'h55, 32'd4, 1'b1);
    check("rw_vl_nochg", 32'(vl), 32'd4);
    csr_access("rs_vl_zero", 2'b10, 12'hC20, 32'd0, 32'd4, 1'b0);
    csr_access("rs_vl_nz", 2'b10, 12'hC20, 32'd1, 32'd4, 1'b1);
    csr_access("rd_unknown", 2'b00, 12'h123, 32'd0, 32'd0, 1'b1);
    csr_access("rw_unknown", 2'b01, 12'h123, 32'h3, 32'd0, 1'b1);
    check("rw_unknown_vxrm", 32'(vxrm), 32'd3);

    // vstart increment, write priority and wrap.
    vstart_inc = 1'b1;
    repeat (3) @(negedge clk);
    vstart_inc = 1'b0;
    check("vstart_inc3", 32'(vstart), 32'd3);
    vstart_inc = 1'b1;
    csr_access("rw_vstart", 2'b01, 12'h008, 32'd5, 32'd3, 1'b0);
    vstart_inc = 1'b0;
    check("vstart_wr_wins", 32'(vstart), 32'd5);
    csr_access("rw_vstart_max", 2'b01, 12'h008, 32'd127, 32'd5, 1'b0);
    vstart_inc = 1'b1;
    @(negedge clk);
    vstart_inc = 1'b0;
    check("vstart_wrap", 32'(vstart), 32'd0);
    csr_access("rw_vstart_9", 2'b01, 12'h008, 32'd9, 32'd0, 1'b0);

    // vset accept clears vstart, even with a concurrent increment.
    cfg_valid = 1'b1; cfg_avl = 32'd3; cfg_vtype = 32'h000;
    cfg_rs1_zero = 1'b0; cfg_rd_zero = 1'b0; vstart_inc = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; vstart_inc = 1'b0;
    check("vset_clr_vstart", 32'(vstart), 32'd0);
    check("vset_clr_vl", 32'(vl), 32'd3);

    // Reset during RESP aborts the response.
    @(negedge clk);
    cfg_valid = 1'b1; cfg_avl = 32'd7; cfg_vtype = 32'h000;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("abort_pre_resp", 32'(cfg_resp_valid), 32'd1);
    n_reset = 1'b0;
    #1;
    check("abort_resp_valid", 32'(cfg_resp_valid), 32'd0);
    check("abort_vill", 32'(vill), 32'd1);
    check("abort_vl", 32'(vl), 32'd0);
    check("abort_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    check("abort_no_pulse", 32'(cfg_resp_valid), 32'd0);
    check("abort_resp_vl", cfg_resp_vl, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_csr_file.md
# vector_csr_file

Parametrised vector CSR file for the vector accelerator. It holds vstart, vxsat, vxrm, vcsr, vl, vtype and vlenb, and executes vsetvl/vsetvli/vsetivli through a valid/ready request with a registered one-cycle response. It also serves Zicsr-style read/write/set/clear access from the APU interface. It sits beside the vector decoder and supplies vl/vsew/vlmul/policy bits to the lanes.

## Interface
- VLEN, 128: vector register length in bits; power of 2, ≥ 64.
- ELEN, 32: maximum element width in bits, 8/16/32/64.
- XLEN, 32: scalar data width.
- Derived: VLENB = VLEN/8; VL_W = $clog2(VLEN)+1; VS_W = $clog2(VLEN).
- clk  in  1  clock
- n_reset  in  1  asynchronous, active-low reset
- cfg_valid  in  1  vset request
- cfg_ready  out  1  request accepted when high with cfg_valid
- cfg_avl  in  XLEN  AVL (rs1 value or uimm)
- cfg_vtype  in  XLEN  requested vtype
- cfg_rs1_zero  in  1  AVL source is x0 (always 0 for vsetivli)
- cfg_rd_zero  in  1  destination is x0
- cfg_resp_valid  out  1  one-cycle pulse, result ready
- cfg_resp_vl  out  XLEN  new vl, written to rd
- csr_req  in  1  CSR access this cycle
- csr_addr  in  12  CSR address
- csr_op  in  2  00 read, 01 RW, 10 RS, 11 RC
- csr_wdata  in  XLEN  operand
- csr_rdata  out  XLEN  old CSR value, combinational
- csr_illegal  out  1  combinational, qualifies csr_req
- sat_set  in  1  lane saturation; ORed into vxsat
- vstart_inc  in  1  element-completion pulse
- vl  out  VL_W  current vl
- vsew, vlmul  out  3 each  vtype fields
- vta, vma, vill  out  1 each  vtype fields
- vxrm  out  2  rounding mode
- vxsat  out  1  sticky saturation flag
- vstart  out  VS_W  current vstart

## Operation
- **Addresses:** 0x008 vstart, 0x009 vxsat, 0x00A vxrm, 0x00F vcsr ({vxrm, vxsat} at [2:0]), 0xC20 vl, 0xC21 vtype, 0xC22 vlenb.
- **Writable CSRs:** vstart, vxsat, vxrm, vcsr.
  - RW writes wdata.
  - RS writes old | wdata.
  - RC writes old & ~wdata.
  - Only implemented bits are stored; unused rdata bits read 0.
- **csr_illegal** is raised for:
  - an unknown address (rdata = 0);
  - a read-only address with RW;
  - a read-only address with RS/RC and wdata ≠ 0.
  - An illegal access changes no state.
- **vtype legality:** the request is vill if any of these holds:
  - vsew > log2(ELEN/8);
  - vlmul = 100;
  - fractional LMUL with SEW > ELEN·LMUL;
  - cfg_vtype[XLEN-2:8] ≠ 0;
  - cfg_vtype[XLEN-1] = 1.
- **VLMAX** = (VLEN >> (3+vsew)) shifted left by vlmul (000–011), or right by 8−vlmul for fractional (101–111).
- **New vl:**
  - rs1≠x0: min(AVL, VLMAX), compared at full XLEN.
  - rs1=x0, rd≠x0: VLMAX.
  - rs1=x0, rd=x0: vl unchanged. If old vl > new VLMAX, the request is treated as vill.
- **vill result:** vtype = {1, 0…}, vl = 0, cfg_resp_vl = 0.
- **Every accepted vset** clears vstart.
- **vstart:** vstart_inc adds 1 with wrap modulo 2^VS_W.
- **FSM:** IDLE → RESP on accept; RESP → IDLE unconditionally.
  - cfg_ready = (state == IDLE).
  - vtype/vl register on the accept edge. cfg_resp_valid/cfg_resp_vl are registered, so they are high for exactly the RESP cycle.
- **Same-cycle priority, vstart:** vset clear > CSR write > vstart_inc.
- **Same-cycle priority, vxsat:** sat_set is ORed after the CSR write result, so sat_set always wins.
- **Reads during accept** return pre-update values.

## Timing
- **Reset:**
  - vill = 1; other vtype bits 0.
  - vl = 0, vstart = 0, vxsat = 0, vxrm = 0.
  - state IDLE, cfg_ready = 1, cfg_resp_valid = 0, cfg_resp_vl = 0.
  - vlenb is constant VLENB.
- **vset latency:** accept in cycle N; new vl/vtype outputs and cfg_resp_valid appear in cycle N+1. Next accept is possible in N+2.
- **CSR writes, sat_set, vstart_inc:** take effect at the next edge. csr_rdata/csr_illegal are combinational in the same cycle.
- **Reset mid-operation:** asserting n_reset in RESP aborts the response. Outputs go to reset values asynchronously, and no cfg_resp_valid pulse follows.

## Test plan
All scenarios use VLEN=128, ELEN=32.
- **Reset:** release n_reset, read 0xC22 -> rdata = 16, vill = 1, vl = 0, cfg_ready = 1; read 0xC21 -> 0x80000000.
- **Normal vsetvli:** cfg_avl = 10, vtype = 0x0D1 (SEW32, LMUL2, vta=1, vma=1), rs1/rd non-zero -> next cycle cfg_resp_valid = 1, cfg_resp_vl = 8, vl = 8, vsew = 010, vlmul = 001, cfg_ready = 0 for that cycle.
- **Illegal and fractional vtype:**
  - vtype = 0x018 (SEW64) -> vill = 1, vl = 0, resp_vl = 0.
  - vtype = 0x015 (SEW32, LMUL1/8) -> vill = 1.
  - vtype = 0x007 (SEW8, LMUL1/2) -> VLMAX = 8.
- **x0 cases:**
  - rs1=x0, rd≠x0, SEW8/LMUL8 -> vl = 128.
  - rs1=x0, rd=x0, SEW8/LMUL1 (VLMAX 16) -> vill = 1, vl = 0.
  - From vl = 4, rs1=x0, rd=x0 with SEW16/LMUL1 -> vl stays 4.
- **Saturation and vxrm:**
  - sat_set pulse -> vxsat = 1.
  - RC 0x009 wdata = 1 together with sat_set -> vxsat stays 1.
  - RW 0x00F wdata = 0x6 -> vxrm = 3, vxsat = 0; reading 0x00F returns 0x6.
- **Illegal writes and vstart:**
  - RW to 0xC20 -> csr_illegal = 1, vl unchanged.
  - RS to 0xC20 with wdata = 0 -> legal.
  - Three vstart_inc pulses -> vstart = 3.
  - RW vstart = 5 together with vstart_inc -> 5.
  - A vset accept -> vstart = 0.
